// File: rtl/stuff_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | stuff_pkg : shared encodings and defaults for the bit-stuffing codec |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
package stuff_pkg;

   typedef enum logic {
      MODE_TX = 1'b0,
      MODE_RX = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR  = 2'd2
   } rx_state_e;

   localparam int c_RUN_LEN_DEFAULT   = 6;
   localparam int c_SOP_ZEROS_DEFAULT = 7;

endpackage
`default_nettype wire

// File: rtl/bit_stuff_codec_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bit_stuff_codec_if : serial bit-stream handshake in and out          |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
interface bit_stuff_codec_if;

   logic in_valid;
   logic in_bit;
   logic in_ready;
   logic out_valid;
   logic out_bit;

   modport master (
      output in_valid,
      output in_bit,
      input  in_ready,
      input  out_valid,
      input  out_bit
   );

   modport slave (
      input  in_valid,
      input  in_bit,
      output in_ready,
      output out_valid,
      output out_bit
   );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at MAX, synchronous clear       |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module sat_counter #(
   parameter int unsigned  W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // Clear outranks increment so a clear never loses to a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (inc && (r_count != MAX)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bit_stuff_codec.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bit_stuff_codec : HDLC-style zero-bit stuffer (TX) / unstuffer (RX)  |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module bit_stuff_codec
   import stuff_pkg::*;
#(
   parameter int RUN_LEN   = c_RUN_LEN_DEFAULT,
   parameter int SOP_ZEROS = c_SOP_ZEROS_DEFAULT,
   parameter int STAT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic                  start,
   input  logic                  recving,
   input  logic                  clr_stats,
   bit_stuff_codec_if.slave      bus,
   output logic                  sending,
   output logic                  stuff_err,
   output logic [STAT_W-1:0]     stuff_cnt
);

   localparam int c_RUN_W  = 4;
   localparam int c_ZERO_W = $clog2(SOP_ZEROS + 1);
   localparam logic [c_RUN_W-1:0]  c_RUN_MAX  = c_RUN_W'(RUN_LEN);
   localparam logic [c_ZERO_W-1:0] c_ZERO_MAX = c_ZERO_W'(SOP_ZEROS);

   rx_state_e             r_state;
   rx_state_e             w_state_nxt;
   mode_e                 w_mode;
   mode_e                 r_mode_q;
   logic                  w_mode_chg;
   logic                  r_out_valid;
   logic                  r_out_bit;
   logic                  r_stuff_err;
   logic                  w_ov_nxt;
   logic                  w_ob_nxt;
   logic                  w_err_nxt;
   logic                  w_run_clr;
   logic                  w_run_inc;
   logic                  w_zero_clr;
   logic                  w_zero_inc;
   logic                  w_stat_inc;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_stuff_due;
   logic [c_RUN_W-1:0]    w_run_cnt;
   logic [c_ZERO_W-1:0]   w_zero_cnt;

   assign w_mode      = mode_e'(mode);
   assign w_mode_chg  = (w_mode != r_mode_q);
   assign w_stuff_due = (w_run_cnt == c_RUN_MAX);

   // The flush cycle of a switch into TX takes no bit; RX always takes one.
   assign w_in_ready = (w_mode == MODE_RX) ? 1'b1 : (!w_mode_chg && !w_stuff_due);
   assign w_accept   = bus.in_valid && w_in_ready;

   always_ff @(posedge clk) begin
      r_mode_q <= w_mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ov_nxt    = 1'b0;
      w_ob_nxt    = r_out_bit;
      w_err_nxt   = 1'b0;
      w_run_clr   = 1'b0;
      w_run_inc   = 1'b0;
      w_zero_clr  = 1'b0;
      w_zero_inc  = 1'b0;
      w_stat_inc  = 1'b0;
      if (w_mode_chg) begin
         w_state_nxt = ST_HUNT;
         w_run_clr   = 1'b1;
         w_zero_clr  = 1'b1;
      end else if (w_mode == MODE_TX) begin
         w_state_nxt = ST_HUNT;
         if (w_stuff_due) begin
            w_ov_nxt   = 1'b1;
            w_ob_nxt   = 1'b0;
            w_run_clr  = 1'b1;
            w_stat_inc = 1'b1;
         end else if (w_accept) begin
            w_ov_nxt = 1'b1;
            w_ob_nxt = bus.in_bit;
            if (start || !bus.in_bit) begin
               w_run_clr = 1'b1;
            end else begin
               w_run_inc = 1'b1;
            end
         end
      end else if (!recving) begin
         w_state_nxt = ST_HUNT;
         w_run_clr   = 1'b1;
         w_zero_clr  = 1'b1;
      end else begin
         case (r_state)
            ST_HUNT: begin
               if (bus.in_valid) begin
                  if (!bus.in_bit) begin
                     w_zero_inc = 1'b1;
                  end else if (w_zero_cnt == c_ZERO_MAX) begin
                     w_state_nxt = ST_DATA;
                     w_run_clr   = 1'b1;
                     w_zero_clr  = 1'b1;
                  end else begin
                     w_zero_clr = 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (bus.in_valid) begin
                  if (w_run_cnt != c_RUN_MAX) begin
                     w_ov_nxt = 1'b1;
                     w_ob_nxt = bus.in_bit;
                     if (bus.in_bit) begin
                        w_run_inc = 1'b1;
                     end else begin
                        w_run_clr = 1'b1;
                     end
                  end else if (!bus.in_bit) begin
                     w_run_clr  = 1'b1;
                     w_stat_inc = 1'b1;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = ST_ERR;
                  end
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_stuff_err <= 1'b0;
      end else begin
         r_out_valid <= w_ov_nxt;
         r_out_bit   <= w_ob_nxt;
         r_stuff_err <= w_err_nxt;
      end
   end

   sat_counter #(.W(c_RUN_W), .MAX(c_RUN_MAX)) u_run_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_run_clr),
      .inc   (w_run_inc),
      .count (w_run_cnt)
   );

   sat_counter #(.W(c_ZERO_W), .MAX(c_ZERO_MAX)) u_zero_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_zero_clr),
      .inc   (w_zero_inc),
      .count (w_zero_cnt)
   );

   sat_counter #(.W(STAT_W), .MAX({STAT_W{1'b1}})) u_stat_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_stats),
      .inc   (w_stat_inc),
      .count (stuff_cnt)
   );

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_bit   = r_out_bit;
   assign sending       = (r_state == ST_DATA);
   assign stuff_err     = r_stuff_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_stuff_codec.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_bit_stuff_codec : scoreboard bench for the bit-stuffing codec     |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module tb_bit_stuff_codec;

   localparam int c_STAT_W = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                mode;
   logic                start;
   logic                recving;
   logic                clr_stats;
   logic                sending;
   logic                stuff_err;
   logic [c_STAT_W-1:0] stuff_cnt;

   int   n_chk       = 0;
   int   n_bad       = 0;
   int   n_err_pulse = 0;
   logic exp_q[$];

   bit_stuff_codec_if bus ();

   bit_stuff_codec #(.RUN_LEN(6), .SOP_ZEROS(7), .STAT_W(c_STAT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .start     (start),
      .recving   (recving),
      .clr_stats (clr_stats),
      .bus       (bus),
      .sending   (sending),
      .stuff_err (stuff_err),
      .stuff_cnt (stuff_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Output monitor: every valid output bit must match the head of the queue.
   always @(negedge clk) begin
      if (stuff_err === 1'b1) n_err_pulse++;
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) check_eq("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
         else                   check_eq("sb_bit", 32'(bus.out_bit), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_seq(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         start        = 1'b0;
      end
   endtask

   task automatic tx_bit(input logic b, input logic s, output int stalls);
      stalls = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      start        = s;
      #1;
      while (!bus.in_ready && stalls < 4) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (!bus.in_ready) check_eq("tx_ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic rx_bit(input logic b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, "_out_bit"},   32'(bus.out_bit),   32'd0);
      check_eq({tag, "_sending"},   32'(sending),       32'd0);
      check_eq({tag, "_stuff_err"}, 32'(stuff_err),     32'd0);
      check_eq({tag, "_stuff_cnt"}, 32'(stuff_cnt),     32'd0);
      check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
   endtask

   initial begin
      int st;
      int tot;
      int err_base;
      rst = 1'b1; mode = 1'b0; start = 1'b0; recving = 1'b0; clr_stats = 1'b0;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // TX: eight 1s -> 111111 0 11, stall on the seventh bit
      push_seq(32'b111111011, 9);
      for (int i = 0; i < 8; i++) begin
         tx_bit(1'b1, 1'b0, st);
         if (i == 0) check_eq("tx_stall_bit1", 32'(st), 32'd0);
         if (i == 6) check_eq("tx_stall_bit7", 32'(st), 32'd1);
      end
      idle(2);
      check_eq("tx_cnt_after_8", 32'(stuff_cnt), 32'd1);
      check_eq("tx_idle_out_valid", 32'(bus.out_valid), 32'd0);

      // TX: an accepted 0 restarts the run
      push_seq(32'b011111011111101, 15);
      begin
         logic [13:0] pat;
         pat = 14'b01111101111111;
         for (int i = 13; i >= 0; i--) begin
            tx_bit(pat[i], 1'b0, st);
            if (i == 0) check_eq("tx_zero_clears_stall", 32'(st), 32'd1);
         end
      end
      idle(2);
      check_eq("tx_cnt_zero_run", 32'(stuff_cnt), 32'd2);

      // TX: start bit does not count toward the run
      @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      push_seq(32'b111111101, 9);
      tx_bit(1'b1, 1'b1, st);
      for (int i = 1; i < 8; i++) begin
         tx_bit(1'b1, 1'b0, st);
         if (i == 6) check_eq("tx_start_no_early_stuff", 32'(st), 32'd0);
         if (i == 7) check_eq("tx_start_stuff_after6", 32'(st), 32'd1);
      end
      idle(2);
      check_eq("tx_start_cnt", 32'(stuff_cnt), 32'd1);

      // Mode change TX -> RX flushes output, keeps the statistic
      push_seq(32'b11, 2);
      tx_bit(1'b1, 1'b0, st);
      tx_bit(1'b1, 1'b0, st);
      @(negedge clk); mode = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1; start = 1'b0;
      idle(2);
      check_eq("mode_chg_keep_cnt", 32'(stuff_cnt), 32'd1);
      check_eq("mode_chg_sending", 32'(sending), 32'd0);
      check_eq("rx_in_ready", 32'(bus.in_ready), 32'd1);
      recving = 1'b1;

      // RX: SOP then 1111110 1 -> seven 1s, one removed stuff bit
      err_base = n_err_pulse;
      repeat (7) rx_bit(1'b0);
      rx_bit(1'b1);
      check_eq("rx_sop_hunt_sending", 32'(sending), 32'd0);
      push_seq(32'b1111111, 7);
      rx_bit(1'b1);
      check_eq("rx_sop_sending", 32'(sending), 32'd1);
      repeat (5) rx_bit(1'b1);
      rx_bit(1'b0);
      rx_bit(1'b1);
      idle(2);
      check_eq("rx_unstuff_cnt", 32'(stuff_cnt), 32'd2);
      check_eq("rx_no_err", 32'(n_err_pulse - err_base), 32'd0);
      check_eq("rx_still_data", 32'(sending), 32'd1);

      // RX: seven 1s in DATA -> six forwarded, one error pulse, ERR holds
      push_seq(32'b0111111, 7);
      rx_bit(1'b0);
      repeat (7) rx_bit(1'b1);
      idle(2);
      check_eq("rx_err_pulse", 32'(n_err_pulse - err_base), 32'd1);
      check_eq("rx_err_sending", 32'(sending), 32'd0);
      rx_bit(1'b0); rx_bit(1'b1); rx_bit(1'b0);
      repeat (7) rx_bit(1'b0);
      rx_bit(1'b1);
      idle(2);
      check_eq("rx_err_holds", 32'(sending), 32'd0);
      @(negedge clk); recving = 1'b0;
      @(negedge clk); recving = 1'b1;
      repeat (7) rx_bit(1'b0);
      rx_bit(1'b1);
      push_seq(32'b0, 1);
      rx_bit(1'b0);
      check_eq("rx_abort_to_hunt", 32'(sending), 32'd1);

      // RX: only six 0s is no SOP; a long zero run saturates and still works
      @(negedge clk); recving = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk); recving = 1'b1;
      repeat (6) rx_bit(1'b0);
      rx_bit(1'b1);
      rx_bit(1'b0);
      check_eq("rx_six_zeros_hunt", 32'(sending), 32'd0);
      repeat (8) rx_bit(1'b0);
      rx_bit(1'b1);
      push_seq(32'b111, 3);
      rx_bit(1'b1);
      check_eq("rx_long_zero_sop", 32'(sending), 32'd1);
      rx_bit(1'b1);
      rx_bit(1'b1);

      // Mode change RX -> TX clears the run count
      @(negedge clk); mode = 1'b0; bus.in_valid = 1'b0;
      push_seq(32'b11111101, 8);
      tot = 0;
      for (int i = 0; i < 7; i++) begin
         tx_bit(1'b1, 1'b0, st);
         tot += st;
      end
      check_eq("rx2tx_run_cleared", 32'(tot), 32'd1);
      check_eq("rx2tx_stall_last", 32'(st), 32'd1);
      idle(2);
      check_eq("rx2tx_cnt", 32'(stuff_cnt), 32'd3);

      // Statistics saturate at 2^STAT_W-1
      push_seq(32'b111110, 6);
      for (int i = 0; i < 5; i++) tx_bit(1'b1, 1'b0, st);
      for (int g = 0; g < 13; g++) begin
         push_seq(32'b1111110, 7);
         for (int k = 0; k < 6; k++) tx_bit(1'b1, 1'b0, st);
      end
      idle(2);
      check_eq("stat_saturate", 32'(stuff_cnt), 32'd15);

      // clr_stats beats a simultaneous increment
      @(negedge clk); clr_stats = 1'b1;
      push_seq(32'b1111110, 7);
      for (int k = 0; k < 6; k++) tx_bit(1'b1, 1'b0, st);
      idle(2);
      clr_stats = 1'b0;
      #1;
      check_eq("clr_over_inc", 32'(stuff_cnt), 32'd0);

      // Reset with run_cnt=5 discards the run
      push_seq(32'b11111, 5);
      for (int k = 0; k < 5; k++) tx_bit(1'b1, 1'b0, st);
      @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check_reset_state("midrun_reset");
      rst = 1'b0;
      push_seq(32'b1111110, 7);
      tot = 0;
      for (int k = 0; k < 6; k++) begin
         tx_bit(1'b1, 1'b0, st);
         tot += st;
      end
      check_eq("post_reset_no_stuff", 32'(tot), 32'd0);
      idle(3);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bit_stuff_codec.md
BIT_STUFF_CODEC -- requirements
Module: bit_stuff_codec

Interface
REQ-001 SHALL take parameter RUN_LEN, default 6: consecutive 1s after which a 0 is stuffed (TX) or removed (RX); legal range 2..15.
REQ-002 SHALL take parameter SOP_ZEROS, default 7: minimum run of 0s, followed by a 1, that marks start of packet in RX.
REQ-003 SHALL take parameter STAT_W, default 16: width of the stuff-bit statistics counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = stuff (TX), 1 = unstuff (RX).
REQ-007 start  input  1  TX only: the current bit is the first bit of a packet.
REQ-008 recving  input  1  RX only: line activity present; low aborts reception.
REQ-009 in_valid  input  1  in_bit is valid this cycle.
REQ-010 in_bit  input  1  serial input bit.
REQ-011 in_ready  output  1  block accepts in_bit this cycle (combinational).
REQ-012 out_valid  output  1  out_bit is valid (registered).
REQ-013 out_bit  output  1  serial output bit (registered).
REQ-014 sending  output  1  RX: packet payload in progress (state DATA).
REQ-015 stuff_err  output  1  RX: one-cycle pulse, stuffing violation.
REQ-016 clr_stats  input  1  synchronous clear of stuff_cnt.
REQ-017 stuff_cnt  output  STAT_W  saturating count of stuff bits inserted (TX) or removed (RX).

Function
REQ-018 Output latency SHALL be exactly 1 cycle: out_bit/out_valid register the bit accepted, or stuffed, in the previous cycle.
REQ-019 TX: a bit is accepted when in_valid && in_ready; an accepted 1 increments run_cnt, an accepted 0 clears it.
REQ-020 TX: when run_cnt == RUN_LEN, in_ready SHALL be 0, a 0 SHALL be emitted regardless of in_valid, run_cnt SHALL clear, and stuff_cnt SHALL increment.
REQ-021 TX: an accepted bit with start=1 SHALL pass through, clear run_cnt, and not count toward a run.
REQ-022 TX: with no bit accepted and no stuff bit due, out_valid SHALL be 0 on the next cycle.
REQ-023 RX: in_ready SHALL be constantly 1.
REQ-024 RX FSM states: HUNT, DATA, ERR; recving=0 SHALL force HUNT next cycle from any state and clear all counters.
REQ-025 HUNT: a valid 0 increments zero_cnt, which saturates at SOP_ZEROS; a valid 1 with zero_cnt == SOP_ZEROS SHALL go to DATA, otherwise clear zero_cnt; no bits are forwarded in HUNT.
REQ-026 On entering DATA, run_cnt SHALL be 0; the SOP's final 1 SHALL not be forwarded.
REQ-027 DATA, valid bit, run_cnt < RUN_LEN: forward the bit and update run_cnt as in TX.
REQ-028 DATA, valid 0, run_cnt == RUN_LEN: drop the bit (out_valid=0 next cycle), clear run_cnt, increment stuff_cnt.
REQ-029 DATA, valid 1, run_cnt == RUN_LEN: drop the bit, pulse stuff_err for one cycle, go to ERR.
REQ-030 ERR: forward nothing and hold until recving=0.
REQ-031 sending SHALL be 1 exactly while the state is DATA.
REQ-032 A change of mode SHALL, on the next cycle, clear run_cnt and zero_cnt, set the FSM to HUNT, and drive out_valid to 0; stuff_cnt SHALL be kept.
REQ-033 stuff_cnt SHALL saturate at 2^STAT_W-1.
REQ-034 clr_stats SHALL take priority over a simultaneous increment of stuff_cnt.

Reset
REQ-035 rst=1 at a clock edge SHALL set out_valid=0, out_bit=0, sending=0, stuff_err=0, stuff_cnt=0, run_cnt=0, zero_cnt=0, FSM=HUNT; in_ready SHALL follow from the cleared state (1).
REQ-036 Reset mid-packet SHALL discard any pending stuff bit; the first bit after reset is never a stuff bit.

Structure
REQ-037 Package stuff_pkg SHALL hold: the mode encoding enum, the RX state enum, and the RUN_LEN and SOP_ZEROS defaults.
REQ-038 run_cnt and zero_cnt SHALL each be an instance of sub-module sat_counter, parametrised by width and max value, with synchronous active-high clear.

Verification
REQ-039 TX, RUN_LEN=6: eight 1s, in_valid held high -> output 1111110 11; in_ready low on cycle 7; stuff_cnt=1.
REQ-040 RX: 0000000 1 then 1111110 1 -> sending rises, output 1111111 (0 dropped), stuff_cnt=1, no stuff_err.
REQ-041 RX in DATA: seven consecutive 1s -> six forwarded, stuff_err pulse for one cycle, state ERR; recving=0 -> HUNT.
REQ-042 RX HUNT: 000000 1 (only six 0s) -> stays in HUNT, sending=0.
REQ-043 TX with start=1 on a 1 followed by six 1s -> no stuff after the start bit; stuff inserted only after six non-start 1s.
REQ-044 rst asserted while run_cnt=5, and with stuff_cnt at its maximum under clr_stats+increment -> all outputs at reset values; stuff_cnt=0.
